// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with a two-entry skid buffer and synchronous flush.
// Optional stall counter port `stall_cycles` is enabled by defining IDS_STALL_CNT_EN.
module instr_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [24:0]     out_imm_data,
  output logic [2:0]      out_imm_src,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
`ifdef IDS_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  // Returns {illegal, imm_src}.
  function automatic logic [3:0] decode_op(input logic [6:0] op);
    logic [3:0] r;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: r = {1'b0, 3'd0};
      7'b0100011:                         r = {1'b0, 3'd1};
      7'b1100011:                         r = {1'b0, 3'd2};
      7'b1101111:                         r = {1'b0, 3'd3};
      7'b0110111, 7'b0010111:             r = {1'b0, 3'd4};
      7'b0110011:                         r = {1'b0, 3'd0};
      default:                            r = {1'b1, 3'd0};
    endcase
    return r;
  endfunction

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;
  logic            load_main, load_skid;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;
  logic [3:0]      src_dec;
  logic            accept, rel;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid && in_ready;
  assign rel       = main_valid_q && out_ready;
  assign src_dec   = decode_op(src_instr[6:0]);

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    src_instr    = in_instr;
    src_pc       = in_pc;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || rel) begin
      if (skid_valid_q) begin
        // Skid content is older than any new input, so it moves up first.
        src_instr    = skid_instr_q;
        src_pc       = skid_pc_q;
        load_main    = 1'b1;
        main_valid_d = 1'b1;
        load_skid    = accept;
        skid_valid_d = accept;
      end else if (accept) begin
        load_main    = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      out_pc       <= '0;
      out_imm_data <= '0;
      out_imm_src  <= '0;
      out_opcode   <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      if (load_skid) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
      if (load_main) begin
        out_pc       <= src_pc;
        out_imm_data <= src_instr[31:7];
        out_imm_src  <= src_dec[2:0];
        out_illegal  <= src_dec[3];
        out_opcode   <= src_instr[6:0];
        out_rd       <= src_instr[11:7];
        out_funct3   <= src_instr[14:12];
        out_rs1      <= src_instr[19:15];
        out_rs2      <= src_instr[24:20];
        out_funct7b5 <= src_instr[30];
      end
    end
  end

`ifdef IDS_STALL_CNT_EN
  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (main_valid_q && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: driver pushes expected decodes, monitor pops on release.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [24:0] imm;
    logic [2:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [24:0] out_imm_data;
  logic [2:0]  out_imm_src, out_funct3;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_funct7b5, out_illegal;
`ifdef IDS_STALL_CNT_EN
  logic [31:0] stall_cycles;
  int unsigned exp_stall = 0;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  instr_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm_data(out_imm_data), .out_imm_src(out_imm_src), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
`ifdef IDS_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [2:0] src, input logic ill);
    exp_t e;
    e.pc  = pc;
    e.imm = instr[31:7];
    e.src = src;
    e.op  = instr[6:0];
    e.rd  = instr[11:7];
    e.rs1 = instr[19:15];
    e.rs2 = instr[24:20];
    e.f3  = instr[14:12];
    e.f7  = instr[30];
    e.ill = ill;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the input until accepted; the expected decode is queued at the accepting edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [2:0] src, input logic ill);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(mk(instr, pc, src, ill));
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every release must match the oldest expected decode.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
`ifdef IDS_STALL_CNT_EN
      if (!rst_n) exp_stall = 0;
      else if (out_valid && !out_ready) exp_stall++;
`endif
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=pc_%0h required=no_output", out_pc);
        end else begin
          e = sb.pop_front();
          chk("scoreboard_decode",
              {out_pc, out_imm_data, out_imm_src, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7b5, out_illegal}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_imm_src", out_imm_src, 3'd0);
    chk("reset_illegal", out_illegal, 1'b0);
`ifdef IDS_STALL_CNT_EN
    chk("reset_stall", stall_cycles, 32'd0);
`endif
    #10 rst_n = 1'b1;
    step();

    // Single I-type, latency 1
    send(32'h0050_0093, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_imm_src", out_imm_src, 3'd0);
    chk("t1_imm_data", out_imm_data, 25'h000A001);
    chk("t1_rd", out_rd, 5'd1);
    chk("t1_illegal", out_illegal, 1'b0);
    step();
    @(negedge clk);
    chk("t1_drained", out_valid, 1'b0);
    step();

    // Back-to-back S, B, J, U
    send(32'h0020_A423, 32'h100, 3'd1, 1'b0);
    send(32'h0000_0063, 32'h104, 3'd2, 1'b0);
    send(32'h0000_00EF, 32'h108, 3'd3, 1'b0);
    send(32'h1234_52B7, 32'h10C, 3'd4, 1'b0);
    @(negedge clk);
    chk("t2_u_imm_src", out_imm_src, 3'd4);
    chk("t2_u_imm_data", out_imm_data, 25'h02468A5);
    chk("t2_u_rd", out_rd, 5'd5);
    step();
    step();

    // Back-pressure: main and skid fill, third input waits
    out_ready = 1'b0;
    send(32'h0010_0113, 32'h200, 3'd0, 1'b0);
    send(32'h0020_0193, 32'h204, 3'd0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0030_0213; in_pc = 32'h208;
    @(negedge clk);
    chk("t3_in_ready_low", in_ready, 1'b0);
    chk("t3_main_head", out_pc, 32'h200);
    step(); step(); step();
`ifdef IDS_STALL_CNT_EN
    chk("t3_stall_held", stall_cycles, 32'd4);
`endif
    out_ready = 1'b1;
    send(32'h0030_0213, 32'h208, 3'd0, 1'b0);
    step(); step();
`ifdef IDS_STALL_CNT_EN
    chk("t3_stall_model", stall_cycles, exp_stall);
`endif
    chk("t3_all_emerged", sb.size(), 0);

    // Flush with both entries full and a concurrent input
    out_ready = 1'b0;
    send(32'h0040_0293, 32'h300, 3'd0, 1'b0);
    send(32'h0050_0313, 32'h304, 3'd0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0060_0393; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t4_flush_out_valid", out_valid, 1'b0);
    chk("t4_flush_in_ready", in_ready, 1'b1);
    step();
`ifdef IDS_STALL_CNT_EN
    chk("t4_stall_kept", stall_cycles, exp_stall);
`endif
    out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("t4_nothing_after_flush", out_valid, 1'b0);
    step();

    // Illegal and R-type
    send(32'hFFFF_FFFF, 32'h400, 3'd0, 1'b1);
    @(negedge clk);
    chk("t5_illegal", out_illegal, 1'b1);
    chk("t5_illegal_src", out_imm_src, 3'd0);
    step();
    send(32'h0000_0033, 32'h404, 3'd0, 1'b0);
    @(negedge clk);
    chk("t5_rtype_legal", out_illegal, 1'b0);
    step(); step();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h0070_0413, 32'h500, 3'd0, 1'b0);
    send(32'h0080_0493, 32'h504, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", out_valid, 1'b0);
    chk("t6_async_in_ready", in_ready, 1'b1);
    chk("t6_async_pc", out_pc, 32'h0);
    chk("t6_async_imm_data", out_imm_data, 25'h0);
`ifdef IDS_STALL_CNT_EN
    chk("t6_async_stall", stall_cycles, 32'd0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("t6_after_reset_idle", out_valid, 1'b0);
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered decode stage between the instruction-fetch path and the immediate extender / register file. It accepts a fetched instruction and its PC over a valid/ready handshake and splits the instruction into register, function and immediate fields. It derives the 3-bit immediate-select code and presents the raw 25-bit immediate field `instr[31:7]` to the extender. A two-entry skid buffer gives full throughput under downstream back-pressure, and a synchronous flush discards in-flight instructions on redirects.

## Interface
- `XLEN`, default 32: PC width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous discard of all held instructions.
- `in_valid`  in  1: `in_instr` and `in_pc` are valid.
- `in_ready`  out  1: stage can accept; equals `!skid_valid`.
- `in_instr`  in  32: instruction word.
- `in_pc`  in  XLEN: PC of the instruction.
- `out_valid`  out  1: decoded outputs are valid.
- `out_ready`  in  1: consumer accepts this cycle.
- `out_pc`  out  XLEN: PC.
- `out_imm_data`  out  25: `instr[31:7]`, fed to the extender's data input.
- `out_imm_src`  out  3: I=0, S=1, B=2, J=3, U=4.
- `out_opcode`  out  7, `out_rd`  out  5, `out_rs1`  out  5, `out_rs2`  out  5, `out_funct3`  out  3, `out_funct7b5`  out  1: fields of the instruction.
- `out_illegal`  out  1: opcode not recognised.
- `stall_cycles`  out  32: present only with `IDS_STALL_CNT_EN`.

## Operation
- State: main entry (`main_valid` plus fields) and skid entry (`skid_valid` plus raw instr/pc). Outputs are driven from the main entry. `out_valid = main_valid`.
- Decode happens on entry into main, so outputs are registers. The opcode maps to `imm_src` as follows:
  - 0000011, 0010011, 1100111 → 0
  - 0100011 → 1
  - 1100011 → 2
  - 1101111 → 3
  - 0110111, 0010111 → 4
  - 0110011 → 0 with `illegal=0`
  - any other opcode → 0 with `illegal=1`
- Accept: `in_valid && in_ready`. Release: `out_valid && out_ready`.
- Per-edge update, in priority order:
  - `flush=1`: `main_valid=0` and `skid_valid=0`. A concurrent input is dropped and a concurrent release still counts as consumed.
  - Main empty or releasing: main loads the skid entry if `skid_valid` (skid clears, input then goes to skid if accepted). Otherwise main loads the input if accepted, else `main_valid=0`.
  - Main full and not releasing: an accepted input goes to skid.
- The skid is never overwritten while valid, because `in_ready=0` then.
- Order is strictly preserved: skid content always precedes new input.
- Field registers hold their last value when `main_valid=0`. The consumer qualifies them with `out_valid`.

## Timing
- Latency 1: input accepted at edge N appears on outputs from edge N through the next release.
- Throughput 1 instruction/cycle while `out_ready=1`.
- `in_ready` is registered (from `skid_valid`). After `out_ready` returns, it reasserts one cycle later, once the skid drains into main.
- Reset (`rst_n=0`, asynchronous): all outputs are 0 (`out_valid=0`, `out_imm_src=0`, `out_illegal=0`, `stall_cycles=0`), `skid_valid=0`, so `in_ready=1`.
- Reset mid-operation discards both entries immediately without waiting for a clock edge.
- After `flush`, `out_valid=0` and `in_ready=1` on the following cycle.

## Configuration
- `IDS_STALL_CNT_EN` defined:
  - adds `stall_cycles`, which increments each edge where `out_valid && !out_ready` and saturates at 0xFFFFFFFF;
  - cleared by reset only, not by flush.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then `in_instr=0x00500093`, `in_pc=0x0` for one cycle with `out_ready=1` → next cycle `out_valid=1`, `out_imm_src=0`, `out_imm_data=0x000A001`, `out_rd=1`, `out_illegal=0`. The cycle after, `out_valid=0`.
- Back-to-back stream 0x0020A423, 0x00000063, 0x000000EF, 0x123452B7 with `out_ready=1` → `imm_src` 1, 2, 3, 4 on consecutive cycles. The last has `out_imm_data=0x02468A5` and `out_rd=5`.
- Hold `out_ready=0` while streaming 3 instructions → first two accepted (main, skid), `in_ready=0` on the third. Raise `out_ready` → all three emerge in order with no loss or duplication. With `IDS_STALL_CNT_EN`, `stall_cycles` equals the number of held cycles.
- Main and skid full, assert `flush` with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`. The flushed-cycle input never appears.
- `in_instr=0xFFFFFFFF` → `out_illegal=1`, `out_imm_src=0`. Pull `rst_n` low mid-stall → outputs zero asynchronously, before the next edge.
